tensor_scalar_add_collector: RTL

//  Downstream stage of the tensor scalar add/sub unit. Captures its out_valid/out_result stream into a small FIFO.

---
 rtl/tensor_scalar_add_collector_pkg.sv | 20 ++
 rtl/tensor_scalar_result_fifo.sv | 64 ++++++
 rtl/tensor_scalar_add_collector.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tensor_scalar_add_collector_pkg.sv
// rtl/tensor_scalar_add_collector_pkg.sv - shared state encoding and float32 field positions for the result collector
package tensor_scalar_add_collector_pkg;

    localparam logic [1:0] COLLECTOR_IDLE    = 2'd0;
    localparam logic [1:0] COLLECTOR_COLLECT = 2'd1;
    localparam logic [1:0] COLLECTOR_DRAIN   = 2'd2;
    localparam logic [1:0] COLLECTOR_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = COLLECTOR_IDLE,
        ST_COLLECT = COLLECTOR_COLLECT,
        ST_DRAIN   = COLLECTOR_DRAIN,
        ST_DONE    = COLLECTOR_DONE
    } collector_state_t;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;

endpackage

// File: rtl/tensor_scalar_result_fifo.sv
// rtl/tensor_scalar_result_fifo.sv - synchronous result FIFO holding data plus a per-entry last flag
module tensor_scalar_result_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstnn,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          head_last,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_data [DEPTH];
    logic          mem_last [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tensor_scalar_add_collector.sv
// rtl/tensor_scalar_add_collector.sv - collects add/sub results into a FIFO per job; float status under TENSOR_COLLECTOR_FLOAT_STATUS_EN
module tensor_scalar_add_collector
    import tensor_scalar_add_collector_pkg::*;
#(
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int BW_COUNT         = 16
) (
    input  logic                        clk,
    input  logic                        rstnn,
    input  logic                        clear,
    input  logic                        start,
    input  logic [BW_COUNT-1:0]         cfg_length,
    input  logic                        is_float,
    output logic                        adder_enable,
    input  logic                        in_valid,
    input  logic [BW_TENSOR_SCALAR-1:0] in_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BW_TENSOR_SCALAR-1:0] out_data,
    output logic                        out_last,
    output logic                        done,
    output logic                        err_unexpect,
    output logic                        nan_seen,
    output logic                        inf_seen
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    collector_state_t    state_q, state_d;
    logic [BW_COUNT-1:0] remaining_q;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                push_last;

    assign adder_enable = (state_q == ST_COLLECT) && !fifo_full;
    assign push         = in_valid & adder_enable;
    assign out_valid    = ~fifo_empty;
    assign pop          = out_valid & out_ready;
    assign push_last    = (remaining_q == BW_COUNT'(1));
    assign done         = (state_q == ST_DONE);

    tensor_scalar_result_fifo #(
        .W     (BW_TENSOR_SCALAR),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear),
        .push      (push),
        .push_data (in_result),
        .push_last (push_last),
        .pop       (pop),
        .head_data (out_data),
        .head_last (out_last),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (cfg_length != '0) ? ST_COLLECT : ST_DONE;
            end
            ST_COLLECT: begin
                if (push && push_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty || (fifo_count == CW'(1) && pop)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            err_unexpect <= 1'b0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            err_unexpect <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) remaining_q <= cfg_length;
            else if (push)                   remaining_q <= remaining_q - BW_COUNT'(1);
            if (in_valid && state_q != ST_COLLECT) err_unexpect <= 1'b1;
        end
    end

`ifdef TENSOR_COLLECTOR_FLOAT_STATUS_EN
    logic special;
    assign special = push && is_float && (&in_result[EXP_MSB:EXP_LSB]);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            nan_seen <= 1'b0;
            inf_seen <= 1'b0;
        end else if (clear) begin
            nan_seen <= 1'b0;
            inf_seen <= 1'b0;
        end else if (special) begin
            if (|in_result[MAN_MSB:0]) nan_seen <= 1'b1;
            else                       inf_seen <= 1'b1;
        end
    end
`else
    logic unused_float;
    assign unused_float = is_float;
    assign nan_seen     = 1'b0;
    assign inf_seen     = 1'b0;
`endif

endmodule
